// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the unified memory-port
//               arbiter: FSM state encoding, request-owner encoding, default
//               address/data widths and the latency-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int C_DEF_AW = 32;
    localparam int C_DEF_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    // The counter only ever holds MEM_LATENCY-1, so it needs enough bits for
    // that value and never fewer than one bit.
    function automatic int lat_cnt_width(input int lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_lat_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_lat_counter
// Description : Loadable down-counter that times the memory read latency.
//               Loads MEM_LATENCY-1, decrements while enabled, saturates at
//               zero and flags when zero is reached.
// Ports       : clk, reset (async, active-low)
//               i_load  - load MEM_LATENCY-1
//               i_dec   - decrement by one (ignored at zero)
//               o_zero  - counter value is zero
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int             C_W    = lat_cnt_width(MEM_LATENCY);
    localparam logic [C_W-1:0] C_LOAD = C_W'(MEM_LATENCY - 1);

    logic [C_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= C_LOAD;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - C_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one unified memory port between instruction fetch (IF)
//               and the MEM-stage data requester (DM). One request at a time,
//               fixed priority DM over IF, fixed memory latency, one-cycle
//               response pulse to the owning requester.
// Ports       : clk, reset (async, active-low)
//               if_req_*  / if_resp_*  - fetch request / response
//               dm_req_*  / dm_resp_*  - data request / response
//               mem_*                  - memory command and read data
//               busy                   - arbiter not in IDLE
//               perf_*                 - grant/conflict counters (optional)
// Options     : MEM_PORT_ARBITER_PERF_EN - adds perf_if_grants,
//               perf_dm_grants and perf_conflicts outputs and their counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = C_DEF_AW,
    parameter int DW          = C_DEF_DW,
    parameter int MEM_LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req_valid,
    input  logic [AW-1:0] if_req_addr,
    output logic          if_req_ready,
    output logic          if_resp_valid,
    output logic [DW-1:0] if_resp_data,
    input  logic          dm_req_valid,
    input  logic          dm_req_we,
    input  logic [AW-1:0] dm_req_addr,
    input  logic [DW-1:0] dm_req_wdata,
    output logic          dm_req_ready,
    output logic          dm_resp_valid,
    output logic [DW-1:0] dm_resp_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0]   perf_if_grants,
    output logic [31:0]   perf_dm_grants,
    output logic [31:0]   perf_conflicts
`endif
);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    arb_owner_t    r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;

    logic          w_idle;
    logic          w_issue;
    logic          w_wait;
    logic          w_resp;
    logic          w_cnt_zero;
    logic          w_dm_hs;
    logic          w_if_hs;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idle      = 1'b0;
        w_issue     = 1'b0;
        w_wait      = 1'b0;
        w_resp      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idle = 1'b1;
                if (dm_req_valid || if_req_valid) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue     = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_wait = 1'b1;
                if (w_cnt_zero) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_resp      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // DM wins a same-cycle collision: the MEM-stage instruction is older.
    assign w_dm_hs      = w_idle && dm_req_valid;
    assign w_if_hs      = w_idle && if_req_valid && !dm_req_valid;
    assign dm_req_ready = w_idle;
    assign if_req_ready = w_idle && !dm_req_valid;
    assign busy         = !w_idle;

    // ------------------------------------------------------------------------
    // Request latch and read-data capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_dm_hs) begin
                r_owner <= OWN_DM;
                r_we    <= dm_req_we;
                r_addr  <= dm_req_addr;
                r_wdata <= dm_req_wdata;
            end else if (w_if_hs) begin
                r_owner <= OWN_IF;
                r_we    <= 1'b0;
                r_addr  <= if_req_addr;
                r_wdata <= '0;
            end
            if (w_wait && w_cnt_zero) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    mem_arb_lat_counter #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_lat_counter (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_issue),
        .i_dec  (w_wait),
        .o_zero (w_cnt_zero)
    );

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Address and write data keep their last latched values between
    // commands; only the strobes are qualified by state.
    assign mem_en        = w_issue;
    assign mem_we        = w_issue && r_we;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;

    assign if_resp_valid = w_resp && (r_owner == OWN_IF);
    assign dm_resp_valid = w_resp && (r_owner == OWN_DM);
    assign if_resp_data  = r_rdata;
    assign dm_resp_data  = r_we ? '0 : r_rdata;

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] r_perf_if;
    logic [31:0] r_perf_dm;
    logic [31:0] r_perf_conf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_if   <= '0;
            r_perf_dm   <= '0;
            r_perf_conf <= '0;
        end else begin
            if (w_if_hs) begin
                r_perf_if <= r_perf_if + 32'd1;
            end
            if (w_dm_hs) begin
                r_perf_dm <= r_perf_dm + 32'd1;
            end
            if (w_idle && if_req_valid && dm_req_valid) begin
                r_perf_conf <= r_perf_conf + 32'd1;
            end
        end
    end

    assign perf_if_grants = r_perf_if;
    assign perf_dm_grants = r_perf_dm;
    assign perf_conflicts = r_perf_conf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Directed scenarios
//               followed by random IF/DM traffic, all checked every cycle
//               against a transaction-timing reference model and a reference
//               memory image.
// Options     : MEM_PORT_ARBITER_PERF_EN - also checks the perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int C_AW  = 32;
    localparam int C_DW  = 32;
    localparam int C_LAT = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            if_req_valid = 1'b0;
    logic [C_AW-1:0] if_req_addr = '0;
    logic            if_req_ready;
    logic            if_resp_valid;
    logic [C_DW-1:0] if_resp_data;
    logic            dm_req_valid = 1'b0;
    logic            dm_req_we = 1'b0;
    logic [C_AW-1:0] dm_req_addr = '0;
    logic [C_DW-1:0] dm_req_wdata = '0;
    logic            dm_req_ready;
    logic            dm_resp_valid;
    logic [C_DW-1:0] dm_resp_data;
    logic            mem_en;
    logic            mem_we;
    logic [C_AW-1:0] mem_addr;
    logic [C_DW-1:0] mem_wdata;
    logic [C_DW-1:0] mem_rdata;
    logic            busy;
`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0]     perf_if_grants;
    logic [31:0]     perf_dm_grants;
    logic [31:0]     perf_conflicts;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW          (C_AW),
        .DW          (C_DW),
        .MEM_LATENCY (C_LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_resp_valid (if_resp_valid),
        .if_resp_data  (if_resp_data),
        .dm_req_valid  (dm_req_valid),
        .dm_req_we     (dm_req_we),
        .dm_req_addr   (dm_req_addr),
        .dm_req_wdata  (dm_req_wdata),
        .dm_req_ready  (dm_req_ready),
        .dm_resp_valid (dm_resp_valid),
        .dm_resp_data  (dm_resp_data),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .busy          (busy)
`ifdef MEM_PORT_ARBITER_PERF_EN
        ,
        .perf_if_grants (perf_if_grants),
        .perf_dm_grants (perf_dm_grants),
        .perf_conflicts (perf_conflicts)
`endif
    );

    // Power-up content of the memory for words never written.
    function automatic logic [31:0] mem_init(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    // ------------------------------------------------------------------------
    // Memory with a fixed read latency; returns junk when no read is due.
    // ------------------------------------------------------------------------
    logic [31:0] r_mem   [0:255];
    bit          r_wr    [0:255];
    logic [31:0] r_pipe  [0:C_LAT-1];
    bit          r_pipe_v[0:C_LAT-1];
    logic [31:0] r_junk = 32'hA5A5_0000;

    always @(posedge clk) begin
        for (int i = C_LAT - 1; i > 0; i--) begin
            r_pipe[i]   <= r_pipe[i-1];
            r_pipe_v[i] <= r_pipe_v[i-1];
        end
        r_pipe_v[0] <= mem_en && !mem_we;
        r_pipe[0]   <= r_wr[mem_addr[7:0]] ? r_mem[mem_addr[7:0]] : mem_init(mem_addr[7:0]);
        if (mem_en && mem_we) begin
            r_mem[mem_addr[7:0]] <= mem_wdata;
            r_wr[mem_addr[7:0]]  <= 1'b1;
        end
        r_junk <= $urandom;
    end

    assign mem_rdata = r_pipe_v[C_LAT-1] ? r_pipe[C_LAT-1] : r_junk;

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got=0x%0h exp=0x%0h", tag, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a request accepted at the end of cycle c is issued in
    // cycle c+1, answered in cycle c+L+2, and the port is free from c+L+3.
    // ------------------------------------------------------------------------
    logic [31:0] ref_mem [0:255];
    bit          ref_wr  [0:255];

    int          cyc     = 0;
    int          m_free  = 0;
    int          m_issue = -1;
    int          m_resp  = -1;
    bit          m_own_dm = 1'b0;
    bit          m_we    = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_exp   = '0;
    logic [31:0] m_perf_if = '0;
    logic [31:0] m_perf_dm = '0;
    logic [31:0] m_perf_cf = '0;

    // Requester-side stimulus state.
    bit          rst_lvl = 1'b0;
    bit          if_v = 1'b0;
    logic [31:0] if_a = '0;
    bit          dm_v = 1'b0;
    bit          dm_w = 1'b0;
    logic [31:0] dm_a = '0;
    logic [31:0] dm_d = '0;
    bit          dm_hold = 1'b0;
    bit          hs_seen = 1'b0;

    task automatic accept(input bit own_dm, input bit we, input logic [31:0] a, input logic [31:0] d);
        m_own_dm = own_dm;
        m_we     = we;
        m_addr   = a;
        m_wdata  = d;
        m_issue  = cyc + 1;
        m_resp   = cyc + C_LAT + 2;
        m_free   = cyc + C_LAT + 3;
        if (we) begin
            m_exp = '0;
            ref_mem[a[7:0]] = d;
            ref_wr[a[7:0]]  = 1'b1;
        end else begin
            m_exp = ref_wr[a[7:0]] ? ref_mem[a[7:0]] : mem_init(a[7:0]);
        end
        hs_seen = 1'b1;
    endtask

    task automatic step();
        bit idle;
        @(posedge clk);
        #1;
        cyc++;
        hs_seen = 1'b0;
        reset        = rst_lvl;
        if_req_valid = if_v;
        if_req_addr  = if_a;
        dm_req_valid = dm_v;
        dm_req_we    = dm_w;
        dm_req_addr  = dm_a;
        dm_req_wdata = dm_d;
        if (!rst_lvl) begin
            m_free    = cyc;
            m_issue   = -1;
            m_resp    = -1;
            m_own_dm  = 1'b0;
            m_we      = 1'b0;
            m_addr    = '0;
            m_perf_if = '0;
            m_perf_dm = '0;
            m_perf_cf = '0;
        end
        #3;
        idle = (cyc >= m_free);
        chk("busy",     busy,          !idle);
        chk("dm_ready", dm_req_ready,  idle);
        chk("if_ready", if_req_ready,  idle && !dm_v);
        chk("mem_en",   mem_en,        cyc == m_issue);
        chk("mem_we",   mem_we,        (cyc == m_issue) && m_we);
        chk("mem_addr", mem_addr,      m_addr);
        if (cyc == m_issue && m_we) chk("mem_wdata", mem_wdata, m_wdata);
        chk("if_rv",    if_resp_valid, (cyc == m_resp) && !m_own_dm);
        chk("dm_rv",    dm_resp_valid, (cyc == m_resp) && m_own_dm);
        if (cyc == m_resp) begin
            if (m_own_dm) chk("dm_rdata", dm_resp_data, m_exp);
            else          chk("if_rdata", if_resp_data, m_exp);
        end
`ifdef MEM_PORT_ARBITER_PERF_EN
        chk("perf_if",   perf_if_grants, m_perf_if);
        chk("perf_dm",   perf_dm_grants, m_perf_dm);
        chk("perf_conf", perf_conflicts, m_perf_cf);
`endif
        // Model of what the coming edge does.
        if (rst_lvl && idle) begin
            if (if_v && dm_v) m_perf_cf++;
            if (dm_v) begin
                m_perf_dm++;
                accept(1'b1, dm_w, dm_a, dm_d);
                if (!dm_hold) dm_v = 1'b0;
                else          dm_a = $urandom_range(0, 63);
            end else if (if_v) begin
                m_perf_if++;
                accept(1'b0, 1'b0, if_a, '0);
                if_v = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the model sees a handshake; an expired budget is a failure.
    task automatic until_hs(input string tag);
        int k = 0;
        do begin
            step();
            k++;
        end while (!hs_seen && k < 40);
        if (!hs_seen) chk(tag, 64'd0, 64'd1);
    endtask

    task automatic reset_pulse(input int n);
        rst_lvl = 1'b0;
        if_v    = 1'b0;
        dm_v    = 1'b0;
        run(n);
        rst_lvl = 1'b1;
    endtask

    initial begin
        // Reset then idle.
        reset_pulse(3);
        run(10);

        // IF read of 0x10 returning 0xDEADBEEF.
        if_v = 1'b1; if_a = 32'h10;
        until_hs("to_if_read");
        run(C_LAT + 4);

        // Collision: DM load 0x20 and IF 0x30 in the same IDLE cycle.
        dm_v = 1'b1; dm_w = 1'b0; dm_a = 32'h20; dm_d = '0;
        if_v = 1'b1; if_a = 32'h30;
        run(2 * (C_LAT + 3) + 4);

        // Store to 0x44, then load it back.
        dm_v = 1'b1; dm_w = 1'b1; dm_a = 32'h44; dm_d = 32'h12345678;
        until_hs("to_store");
        run(C_LAT + 3);
        dm_v = 1'b1; dm_w = 1'b0; dm_a = 32'h44; dm_d = '0;
        until_hs("to_load");
        run(C_LAT + 4);

        // Reset during WAIT of an IF read, then a normal DM request.
        if_v = 1'b1; if_a = 32'h55;
        until_hs("to_if_rst");
        step();
        reset_pulse(2);
        run(8);
        dm_v = 1'b1; dm_w = 1'b0; dm_a = 32'h10; dm_d = '0;
        until_hs("to_dm_after_rst");
        run(C_LAT + 4);

        // Back-to-back DM requests with valid held.
        dm_hold = 1'b1; dm_v = 1'b1; dm_w = 1'b0; dm_a = 32'h21;
        run(3 * (C_LAT + 3) + 2);
        dm_hold = 1'b0; dm_v = 1'b0;
        run(C_LAT + 4);

        // Random traffic with occasional reset during WAIT.
        for (int i = 0; i < 1500; i++) begin
            if (!if_v && ($urandom_range(0, 3) == 0)) begin
                if_v = 1'b1;
                if_a = $urandom_range(0, 63);
            end
            if (!dm_v && ($urandom_range(0, 4) == 0)) begin
                dm_v = 1'b1;
                dm_w = $urandom_range(0, 1);
                dm_a = $urandom_range(0, 63);
                dm_d = $urandom;
            end else if (dm_v && ($urandom_range(0, 15) == 0)) begin
                dm_v = 1'b0;
            end
            if ((cyc + 1 > m_issue) && (cyc + 1 < m_resp) && ($urandom_range(0, 40) == 0)) begin
                reset_pulse($urandom_range(1, 3));
            end else begin
                step();
            end
        end
        if_v = 1'b0; dm_v = 1'b0;
        run(C_LAT + 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the pipeline's single unified memory port between the instruction-fetch (IF) requester and the data-memory (DM) requester of the MEM stage.
- Accepts one request at a time on a valid/ready handshake and issues it to the memory.
- Waits the fixed memory latency, then returns the result to the requester that owns it.
- Sits between the pipeline stages and the memory. The pipeline uses the ready and resp signals as stall/restart conditions.

Parameters:
- AW, 32, address width in bits; word address, passed through unchanged.
- DW, 32, data width in bits.
- MEM_LATENCY, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- if_req_valid  in  1  fetch request.
- if_req_addr  in  AW  fetch address.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_resp_valid  out  1  one-cycle pulse: fetch data valid.
- if_resp_data  out  DW  fetched instruction.
- dm_req_valid  in  1  data request.
- dm_req_we  in  1  1 = store, 0 = load.
- dm_req_addr  in  AW  data address.
- dm_req_wdata  in  DW  store data.
- dm_req_ready  out  1  data request accepted this cycle.
- dm_resp_valid  out  1  one-cycle pulse: load data valid, or store acknowledged.
- dm_resp_data  out  DW  load data; 0 for stores.
- mem_en  out  1  one-cycle memory command strobe.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LATENCY cycles after mem_en.
- busy  out  1  high in every state except IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Encodings live in the package.
- Ready signals are combinational, computed from state and valid:
  - dm_req_ready = (state==IDLE).
  - if_req_ready = (state==IDLE) && !dm_req_valid.
- Arbitration: fixed priority, DM over IF. This is required because the MEM-stage instruction is older. IF starvation is acceptable because the pipeline stalls fetch during MEM accesses.
- IDLE:
  - On a handshake at edge N, latch the owner (IF/DM), we, addr and wdata; go to ISSUE.
  - An IF request is always latched with we=0.
- ISSUE (cycle N+1): mem_en=1, with mem_we/mem_addr/mem_wdata driven from the latched registers. Load the counter with MEM_LATENCY-1; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture mem_rdata at that edge (cycle N+1+MEM_LATENCY) and go to RESP.
- RESP (cycle N+2+MEM_LATENCY):
  - Pulse the owner's resp_valid for exactly one cycle.
  - resp_data comes from the capture register; dm_resp_data=0 for stores.
  - Return to IDLE.
- Latency and throughput:
  - Request-accept edge to resp_valid is MEM_LATENCY+2 cycles.
  - Maximum rate is one request per MEM_LATENCY+3 cycles.
  - No request is accepted in ISSUE, WAIT or RESP.
- Responses have no back-pressure; the requester must take them in the RESP cycle.
- Outside ISSUE: mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last latched values.
- Simultaneous if_req_valid and dm_req_valid in IDLE: DM granted. IF stays unacknowledged, must hold its request, and is granted in a later IDLE cycle.
- Requests deasserted before a handshake are simply ignored; no state change.
- Reset (async, reset=0, any state) forces:
  - state=IDLE; counter=0; owner=IF.
  - All latched registers and the capture register = 0.
  - All *_resp_valid=0; mem_en=0; busy=0.
- Reset mid-operation: any outstanding transaction is dropped and no response is ever emitted for it. The readies follow the combinational rule, so they may rise during reset if valid is present. The bench must hold valids low while reset=0.

Optional Feature:
- Macro: MEM_PORT_ARBITER_PERF_EN.
- Defined:
  - Adds three 32-bit outputs: perf_if_grants, perf_dm_grants, perf_conflicts.
  - The grant counters increment on each handshake.
  - perf_conflicts increments on each IDLE cycle where both valids are high.
  - All three wrap modulo 2^32 and are reset to 0 by reset.
- Not defined: the ports and counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - the owner encoding (OWN_IF=0, OWN_DM=1);
  - default AW/DW constants.
- One natural sub-module, mem_arb_lat_counter: a loadable down-counter whose width is sized from MEM_LATENCY, with a zero flag.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, no valids → busy=0, mem_en=0 and both resp_valid=0 for 10 cycles.
- IF read, MEM_LATENCY=2: if_req_addr=0x10 accepted at edge N, memory model returns 0xDEADBEEF → mem_en=1 with mem_addr=0x10 at N+1; if_resp_valid=1 with data 0xDEADBEEF at N+4, for exactly one cycle.
- Collision: both valid in the same IDLE cycle (dm load 0x20, if 0x30) → DM served first; IF granted at the next IDLE cycle; with PERF_EN, perf_conflicts=1 and perf_dm_grants=1.
- DM store: we=1, addr=0x44, wdata=0x12345678 → mem_we=1 with that addr/data during ISSUE; dm_resp_valid with data 0; a subsequent load of 0x44 returns 0x12345678.
- Reset mid-WAIT: assert reset during WAIT of an IF read → no if_resp_valid ever appears; after release, busy=0 and a new DM request completes normally.
- Back-to-back: DM valid held for two requests → second handshake exactly MEM_LATENCY+3 cycles after the first; ready=0 throughout ISSUE, WAIT and RESP.
